spis_regfile: RTL and testbench
===============================

SPIS_REGFILE -- requirements
Module: spis_regfile

Interface
REQ-001 SHALL have parameter NUM_DIAG, default 2, number of debug capture registers (1..8).
REQ-002 SHALL have parameter NUM_BUF, default 2, number of buffer FIFOs, each with wr and rd side (1..4).
REQ-003 SHALL have parameter SRST_HOLD, default 4, soft-reset pulse length in cycles (1..255).
REQ-004 SHALL have one clock and a synchronous, active-high reset: aclk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-005 SHALL have ports: wdata input 32, write data; write input 1, write strobe; read input 1, read strobe; addr input 16, byte address.
REQ-006 SHALL have ports: rdata output 32, read data; rvalid output 1, rdata valid.
REQ-007 SHALL have ports: avmmtransvld_up input 1, transaction done; s_status_in input 32, live status; s_diag_in input 32*NUM_DIAG, debug buses; load_dbg_bus input NUM_DIAG, per-bus capture strobe.
REQ-008 SHALL have port buf_err_evt input 2*NUM_BUF: bit 2k = buffer k wr-overflow pulse; bit 2k+1 = buffer k rd-underflow pulse.
REQ-009 SHALL have ports: buf_soft_reset output 2*NUM_BUF, per-side soft reset; sft_rst_ctrl output 1; srst_busy output 1, hold FSM active.
REQ-010 SHALL have ports: s_cmd output 32; s_status output 32; s_diag output 32*NUM_DIAG.

Function
REQ-011 SHALL use this register map: 0x00 s_cmd; 0x0C s_status; 0x10+4*i s_diag[i]; 0x40 err_sticky; 0x44 srst_ctrl; 0x48 unmap_cnt.
REQ-012 SHALL load s_cmd from wdata on a write to 0x00.
REQ-013 SHALL clear s_cmd[0] on avmmtransvld_up, which has priority over a write to bit 0; when both occur in the same cycle, bits [31:1] SHALL still take wdata.
REQ-014 SHALL read s_cmd with bits [23:21] forced to 0.
REQ-015 SHALL register s_status from s_status_in every cycle (1-cycle latency); it is read-only.
REQ-016 SHALL capture s_diag[i] from slice i of s_diag_in when load_dbg_bus[i]=1 and otherwise hold it; s_diag is read-only.
REQ-017 SHALL set err_sticky[j] (j<2*NUM_BUF) when buf_err_evt[j]=1 and SHALL clear it on a write-1 to 0x40; set SHALL win over a simultaneous clear; upper bits read 0.
REQ-018 SHALL, on a write to 0x44 with wdata[2*NUM_BUF-1:0] nonzero, OR those bits into buf_soft_reset, load the hold counter with SRST_HOLD-1 and enter HOLD.
REQ-019 SHALL decrement the counter each cycle in HOLD; at count 0, buf_soft_reset SHALL clear and the FSM SHALL return to IDLE, giving exactly SRST_HOLD asserted cycles from the first asserted cycle.
REQ-020 SHALL, on a nonzero write during HOLD, OR in the new bits and reload the counter; zero bits written SHALL NOT deassert an active reset.
REQ-021 SHALL drive srst_busy=1 exactly while in HOLD.
REQ-022 SHALL update sft_rst_ctrl from wdata[8] one cycle after a write to 0x44 cycle (2-cycle write-to-output) and hold it otherwise; it is not affected by the FSM.
REQ-023 SHALL read 0x44 as {sft_rst_ctrl at bit 8, buf_soft_reset at [2*NUM_BUF-1:0]}, other bits 0.
REQ-024 SHALL increment unmap_cnt[15:0], saturating at 0xFFFF, on each write to an address outside the map; any write to 0x48 SHALL clear it, and clear SHALL take precedence.
REQ-025 SHALL register read data: a read at cycle N SHALL give rdata and rvalid=1 at N+1; otherwise rvalid=0 and rdata=0.
REQ-026 SHALL return 0xDEADBEEF for a read of an unmapped address, including s_diag indices >= NUM_DIAG.
REQ-027 SHALL give read precedence when read and write occur together: rdata returns the pre-write value and the write is still performed.

Reset
REQ-028 SHALL, while rst=1 at a clock edge, zero all registers, outputs, counters and sticky bits, set the FSM to IDLE, and drive rvalid=0.
REQ-029 SHALL, on rst asserted during HOLD, deassert buf_soft_reset on the next edge.

Verification
REQ-030 SHALL cover: SRST_HOLD=4, write 0x44 wdata=0x105 -> buf_soft_reset=0x5 for exactly 4 cycles, srst_busy high for the same cycles, sft_rst_ctrl=1 two cycles after the write.
REQ-031 SHALL cover: write 0x44 0x1, then two cycles later write 0x44 0x2 -> buf_soft_reset=0x3 for 4 cycles after the second write.
REQ-032 SHALL cover: write 0x00 0xFFFFFFFF together with avmmtransvld_up -> s_cmd=0xFFFFFFFE; a later read of 0x00 -> 0xFF1FFFFE.
REQ-033 SHALL cover: buf_err_evt[1] pulse in the same cycle as a write of 0x2 to 0x40 -> err_sticky=0x2; a later write of 0x2 -> 0x0.
REQ-034 SHALL cover: 0x10001 writes to 0x80 -> unmap_cnt reads 0xFFFF; a read of 0x80 -> 0xDEADBEEF with rvalid one cycle after read.
REQ-035 SHALL cover: rst asserted mid-HOLD -> all outputs 0 next cycle, and a read of 0x44 returns 0.

Source files
------------

// File: rtl/spis_regfile.sv
// Register file for the SPI-slave bridge: command/status/debug capture registers,
// sticky buffer error flags and a timed per-side buffer soft-reset generator.
module spis_regfile #(
    parameter int NUM_DIAG  = 2,
    parameter int NUM_BUF   = 2,
    parameter int SRST_HOLD = 4
) (
    input  logic                    aclk,
    input  logic                    rst,
    input  logic [31:0]             wdata,
    input  logic                    write,
    input  logic                    read,
    input  logic [15:0]             addr,
    output logic [31:0]             rdata,
    output logic                    rvalid,
    input  logic                    avmmtransvld_up,
    input  logic [31:0]             s_status_in,
    input  logic [32*NUM_DIAG-1:0]  s_diag_in,
    input  logic [NUM_DIAG-1:0]     load_dbg_bus,
    input  logic [2*NUM_BUF-1:0]    buf_err_evt,
    output logic [2*NUM_BUF-1:0]    buf_soft_reset,
    output logic                    sft_rst_ctrl,
    output logic                    srst_busy,
    output logic [31:0]             s_cmd,
    output logic [31:0]             s_status,
    output logic [32*NUM_DIAG-1:0]  s_diag
);
    localparam int          NB        = 2 * NUM_BUF;
    localparam logic [31:0] UNMAPPED  = 32'hDEADBEEF;
    localparam logic [7:0]  HOLD_LOAD = 8'(SRST_HOLD - 1);

    typedef enum logic {ST_IDLE, ST_HOLD} srst_state_e;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    srst_state_e            state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [NB-1:0]          bsr_q, bsr_d;
    logic [31:0]            s_cmd_q, s_cmd_d;
    logic [31:0]            s_status_q;
    logic [32*NUM_DIAG-1:0] s_diag_q, s_diag_d;
    logic [NB-1:0]          err_sticky_q, err_sticky_d;
    logic                   sft_vld_p1_q, sft_bit_p1_q;
    logic                   sft_rst_ctrl_q, sft_rst_ctrl_d;
    logic [15:0]            unmap_cnt_q, unmap_cnt_d;
    logic [31:0]            rdata_q, rdata_d;
    logic                   rvalid_q;

    logic                   sel_cmd, sel_status, sel_err, sel_srst, sel_unmap, mapped;
    logic [NUM_DIAG-1:0]    diag_hit;
    logic [NB-1:0]          srst_bits, err_clr;
    logic [31:0]            rd_word;

    always_comb begin
        sel_cmd    = (addr == 16'h0000);
        sel_status = (addr == 16'h000C);
        sel_err    = (addr == 16'h0040);
        sel_srst   = (addr == 16'h0044);
        sel_unmap  = (addr == 16'h0048);
        diag_hit   = '0;
        for (int i = 0; i < NUM_DIAG; i++) begin
            diag_hit[i] = (addr == 16'(16 + 4 * i));
        end
        mapped = sel_cmd | sel_status | sel_err | sel_srst | sel_unmap | (|diag_hit);
    end

    // Soft-reset hold FSM: state register
    always_ff @(posedge aclk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bsr_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bsr_q   <= bsr_d;
        end
    end

    // Next state: a nonzero write (re)arms the hold, otherwise count down to release
    always_comb begin
        srst_bits = (write && sel_srst) ? wdata[NB-1:0] : '0;
        state_d   = state_q;
        cnt_d     = cnt_q;
        bsr_d     = bsr_q;
        if (|srst_bits) begin
            state_d = ST_HOLD;
            cnt_d   = HOLD_LOAD;
            bsr_d   = bsr_q | srst_bits;
        end else if (state_q == ST_HOLD) begin
            if (cnt_q == 8'd0) begin
                state_d = ST_IDLE;
                bsr_d   = '0;
            end else begin
                cnt_d = cnt_q - 8'd1;
            end
        end
    end

    always_comb begin
        srst_busy = (state_q == ST_HOLD);
    end

    always_comb begin
        s_cmd_d = s_cmd_q;
        if (write && sel_cmd) s_cmd_d = wdata;
        if (avmmtransvld_up)  s_cmd_d[0] = 1'b0;

        s_diag_d = s_diag_q;
        for (int i = 0; i < NUM_DIAG; i++) begin
            if (load_dbg_bus[i]) s_diag_d[32*i +: 32] = s_diag_in[32*i +: 32];
        end

        err_clr      = (write && sel_err) ? wdata[NB-1:0] : '0;
        err_sticky_d = (err_sticky_q & ~err_clr) | buf_err_evt;

        sft_rst_ctrl_d = sft_vld_p1_q ? sft_bit_p1_q : sft_rst_ctrl_q;

        unmap_cnt_d = unmap_cnt_q;
        if (write && sel_unmap)    unmap_cnt_d = '0;
        else if (write && !mapped) unmap_cnt_d = sat_inc(unmap_cnt_q);
    end

    always_comb begin
        rd_word = UNMAPPED;
        if (sel_cmd)    rd_word = s_cmd_q & 32'hFF1F_FFFF;
        if (sel_status) rd_word = s_status_q;
        if (sel_err) begin
            rd_word           = '0;
            rd_word[NB-1:0]   = err_sticky_q;
        end
        if (sel_srst) begin
            rd_word           = '0;
            rd_word[8]        = sft_rst_ctrl_q;
            rd_word[NB-1:0]   = bsr_q;
        end
        if (sel_unmap)  rd_word = {16'h0000, unmap_cnt_q};
        for (int i = 0; i < NUM_DIAG; i++) begin
            if (diag_hit[i]) rd_word = s_diag_q[32*i +: 32];
        end
        rdata_d = read ? rd_word : '0;
    end

    // Stage p1: sft_rst_ctrl write captured here, applied to the output one edge later
    always_ff @(posedge aclk) begin
        if (rst) begin
            s_cmd_q        <= '0;
            s_status_q     <= '0;
            s_diag_q       <= '0;
            err_sticky_q   <= '0;
            sft_vld_p1_q   <= 1'b0;
            sft_bit_p1_q   <= 1'b0;
            sft_rst_ctrl_q <= 1'b0;
            unmap_cnt_q    <= '0;
            rdata_q        <= '0;
            rvalid_q       <= 1'b0;
        end else begin
            s_cmd_q        <= s_cmd_d;
            s_status_q     <= s_status_in;
            s_diag_q       <= s_diag_d;
            err_sticky_q   <= err_sticky_d;
            sft_vld_p1_q   <= write && sel_srst;
            sft_bit_p1_q   <= wdata[8];
            sft_rst_ctrl_q <= sft_rst_ctrl_d;
            unmap_cnt_q    <= unmap_cnt_d;
            rdata_q        <= rdata_d;
            rvalid_q       <= read;
        end
    end

    assign rdata          = rdata_q;
    assign rvalid         = rvalid_q;
    assign buf_soft_reset = bsr_q;
    assign sft_rst_ctrl   = sft_rst_ctrl_q;
    assign s_cmd          = s_cmd_q;
    assign s_status       = s_status_q;
    assign s_diag         = s_diag_q;
endmodule

// File: tb/tb_spis_regfile.sv
// Bench for spis_regfile: behavioural register-map model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_spis_regfile;
    localparam int NUM_DIAG  = 2;
    localparam int NUM_BUF   = 2;
    localparam int SRST_HOLD = 4;
    localparam int NB        = 2 * NUM_BUF;

    logic                   aclk = 1'b0;
    logic                   rst_i;
    logic [31:0]            wdata_i;
    logic                   write_i, read_i, avmm_i;
    logic [15:0]            addr_i;
    logic [31:0]            status_in_i;
    logic [32*NUM_DIAG-1:0] diag_in_i;
    logic [NUM_DIAG-1:0]    load_dbg_i;
    logic [NB-1:0]          evt_i;

    logic [31:0]            rdata;
    logic                   rvalid;
    logic [NB-1:0]          buf_soft_reset;
    logic                   sft_rst_ctrl, srst_busy;
    logic [31:0]            s_cmd, s_status;
    logic [32*NUM_DIAG-1:0] s_diag;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    spis_regfile #(.NUM_DIAG(NUM_DIAG), .NUM_BUF(NUM_BUF), .SRST_HOLD(SRST_HOLD)) dut (
        .aclk(aclk), .rst(rst_i), .wdata(wdata_i), .write(write_i), .read(read_i),
        .addr(addr_i), .rdata(rdata), .rvalid(rvalid), .avmmtransvld_up(avmm_i),
        .s_status_in(status_in_i), .s_diag_in(diag_in_i), .load_dbg_bus(load_dbg_i),
        .buf_err_evt(evt_i), .buf_soft_reset(buf_soft_reset), .sft_rst_ctrl(sft_rst_ctrl),
        .srst_busy(srst_busy), .s_cmd(s_cmd), .s_status(s_status), .s_diag(s_diag)
    );

    always #5 aclk = ~aclk;

    // Reference model state
    logic [31:0]   m_cmd, m_status, m_rdata;
    logic [31:0]   m_diag [NUM_DIAG];
    logic [NB-1:0] m_err, m_bsr;
    logic          m_rvalid, m_sft, m_p_wr, m_p_b8;
    int            m_rem, m_unmap;

    function automatic bit is_mapped(input logic [15:0] a);
        if (a == 16'h00 || a == 16'h0C || a == 16'h40 || a == 16'h44 || a == 16'h48) return 1'b1;
        if (int'(a) >= 16 && int'(a) < 16 + 4 * NUM_DIAG && (int'(a) % 4) == 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_read(input logic [15:0] a);
        logic [31:0] v;
        v = 32'hDEADBEEF;
        if (a == 16'h00) v = m_cmd & 32'hFF1FFFFF;
        else if (a == 16'h0C) v = m_status;
        else if (a == 16'h40) v = 32'(m_err);
        else if (a == 16'h44) v = (32'(m_sft) << 8) | 32'(m_bsr);
        else if (a == 16'h48) v = 32'(m_unmap);
        else if (is_mapped(a)) v = m_diag[(int'(a) - 16) / 4];
        return v;
    endfunction

    task automatic model_step();
        logic [NB-1:0] bits;
        if (rst_i) begin
            m_cmd = 0; m_status = 0; m_rdata = 0; m_rvalid = 0; m_err = 0; m_bsr = 0;
            m_sft = 0; m_p_wr = 0; m_p_b8 = 0; m_rem = 0; m_unmap = 0;
            for (int i = 0; i < NUM_DIAG; i++) m_diag[i] = 0;
        end else begin
            m_rdata  = read_i ? model_read(addr_i) : 32'h0;
            m_rvalid = read_i;
            if (write_i && addr_i == 16'h00) m_cmd = wdata_i;
            if (avmm_i) m_cmd[0] = 1'b0;
            m_status = status_in_i;
            for (int i = 0; i < NUM_DIAG; i++)
                if (load_dbg_i[i]) m_diag[i] = diag_in_i[32*i +: 32];
            if (write_i && addr_i == 16'h40) m_err = m_err & ~wdata_i[NB-1:0];
            m_err = m_err | evt_i;
            // m_rem = number of cycles the soft reset remains visible, counting this one
            bits = (write_i && addr_i == 16'h44) ? wdata_i[NB-1:0] : '0;
            if (bits != 0) begin
                m_bsr = m_bsr | bits;
                m_rem = SRST_HOLD;
            end else if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) m_bsr = '0;
            end
            if (m_p_wr) m_sft = m_p_b8;
            m_p_wr = write_i && addr_i == 16'h44;
            m_p_b8 = wdata_i[8];
            if (write_i && addr_i == 16'h48) m_unmap = 0;
            else if (write_i && !is_mapped(addr_i) && m_unmap < 65535) m_unmap++;
        end
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge aclk);
        model_step();
    end

    initial forever begin
        @(negedge aclk);
        if (chk_en) begin
            check("cmp_rvalid", 32'(rvalid), 32'(m_rvalid));
            check("cmp_rdata", rdata, m_rdata);
            check("cmp_s_cmd", s_cmd, m_cmd);
            check("cmp_s_status", s_status, m_status);
            for (int i = 0; i < NUM_DIAG; i++) check("cmp_s_diag", s_diag[32*i +: 32], m_diag[i]);
            check("cmp_buf_soft_reset", 32'(buf_soft_reset), 32'(m_bsr));
            check("cmp_srst_busy", 32'(srst_busy), 32'(m_rem > 0));
            check("cmp_sft_rst_ctrl", 32'(sft_rst_ctrl), 32'(m_sft));
        end
    end

    task automatic step();
        @(negedge aclk);
    endtask

    task automatic idle();
        rst_i = 0; write_i = 0; read_i = 0; avmm_i = 0; addr_i = 0; wdata_i = 0;
        load_dbg_i = 0; evt_i = 0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d);
        idle(); write_i = 1; addr_i = a; wdata_i = d; step(); idle();
    endtask

    task automatic rd(input logic [15:0] a);
        idle(); read_i = 1; addr_i = a; step(); idle();
    endtask

    int n;

    initial begin
        idle();
        rst_i = 1; status_in_i = 32'h12345678; diag_in_i = '0;
        step();
        chk_en = 1;
        step(); step();
        check("rst_rdata", rdata, 0);
        check("rst_rvalid", 32'(rvalid), 0);
        check("rst_s_cmd", s_cmd, 0);
        check("rst_s_status", s_status, 0);
        check("rst_bsr", 32'(buf_soft_reset), 0);
        check("rst_busy", 32'(srst_busy), 0);
        idle(); step();
        check("status_latency", s_status, 32'h12345678);

        // Debug capture and unmapped diag index
        diag_in_i = {32'hA5A5_0001, 32'h0BAD_F00D}; load_dbg_i = 2'b01; step(); idle();
        rd(16'h10);
        check("diag0_read", rdata, 32'h0BADF00D);
        rd(16'h18);
        check("diag2_unmapped", rdata, 32'hDEADBEEF);

        // Soft reset with sft_rst_ctrl
        wr(16'h44, 32'h105);
        n = 0;
        for (int k = 0; k < 6; k++) begin
            if (buf_soft_reset == 4'h5 && srst_busy) n++;
            if (k == 0) check("r30_sft_one_cycle", 32'(sft_rst_ctrl), 0);
            if (k == 1) check("r30_sft_two_cycles", 32'(sft_rst_ctrl), 1);
            step();
        end
        check("r30_hold_cycles", n, 4);
        check("r30_busy_after", 32'(srst_busy), 0);

        // Re-arm during HOLD
        wr(16'h44, 32'h1);
        step();
        wr(16'h44, 32'h2);
        n = 0;
        for (int k = 0; k < 6; k++) begin
            if (buf_soft_reset == 4'h3) n++;
            step();
        end
        check("r31_merged_cycles", n, 4);

        // Transaction-done clears bit 0 over a simultaneous write
        idle(); write_i = 1; addr_i = 16'h00; wdata_i = 32'hFFFFFFFF; avmm_i = 1; step(); idle();
        check("r32_s_cmd", s_cmd, 32'hFFFFFFFE);
        rd(16'h00);
        check("r32_read_cmd", rdata, 32'hFF1FFFFE);
        check("r32_rvalid", 32'(rvalid), 1);

        // Sticky set wins over clear
        wr(16'h40, 32'hF);
        idle(); write_i = 1; addr_i = 16'h40; wdata_i = 32'h2; evt_i = 4'h2; step(); idle();
        rd(16'h40);
        check("r33_set_wins", rdata, 32'h2);
        wr(16'h40, 32'h2);
        rd(16'h40);
        check("r33_cleared", rdata, 32'h0);

        // Unmapped-write counter saturation
        wr(16'h48, 32'h0);
        idle(); write_i = 1; addr_i = 16'h80; wdata_i = 32'h1;
        for (int k = 0; k < 32'h10001; k++) step();
        idle();
        rd(16'h48);
        check("r34_unmap_sat", rdata, 32'h0000FFFF);
        rd(16'h80);
        check("r34_unmap_read", rdata, 32'hDEADBEEF);
        check("r34_rvalid", 32'(rvalid), 1);
        step();
        check("r34_rvalid_drop", 32'(rvalid), 0);
        check("r34_rdata_zero", rdata, 0);

        // Reset in the middle of HOLD
        wr(16'h44, 32'h10F);
        step();
        rst_i = 1; step(); idle();
        check("r35_bsr", 32'(buf_soft_reset), 0);
        check("r35_busy", 32'(srst_busy), 0);
        check("r35_sft", 32'(sft_rst_ctrl), 0);
        check("r35_s_cmd", s_cmd, 0);
        rd(16'h44);
        check("r35_read_srst", rdata, 0);
        check("r35_rvalid", 32'(rvalid), 1);

        // Randomized traffic against the model
        for (int k = 0; k < 4000; k++) begin
            rst_i   = ($urandom_range(0, 299) == 0);
            write_i = ($urandom_range(0, 9) < 4);
            read_i  = ($urandom_range(0, 9) < 4);
            case ($urandom_range(0, 10))
                0: addr_i = 16'h00;
                1: addr_i = 16'h0C;
                2: addr_i = 16'h10;
                3: addr_i = 16'h14;
                4: addr_i = 16'h18;
                5: addr_i = 16'h40;
                6: addr_i = 16'h44;
                7: addr_i = ($urandom_range(0, 3) == 0) ? 16'h48 : 16'h80;
                8: addr_i = 16'h02;
                default: addr_i = 16'($urandom);
            endcase
            wdata_i = $urandom;
            if ($urandom_range(0, 2) == 0) wdata_i[3:0] = 4'h0;
            avmm_i      = ($urandom_range(0, 7) == 0);
            status_in_i = $urandom;
            diag_in_i   = {$urandom, $urandom};
            load_dbg_i  = 2'($urandom_range(0, 3));
            evt_i       = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
            step();
        end
        idle();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
